// File: rtl/as5401_mem_ctrl.sv
// Program-fetch, data-RAM and program-counter controller for the AS5401 4-bit core,
// with a checker that flags illegal clock_state phase sequences.
module as5401_mem_ctrl #(
    parameter int unsigned PAW = 6,
    parameter int unsigned DAW = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [3:0]     cs,
    input  logic [7:0]     db,
    input  logic           mar,
    input  logic           write,
    input  logic           jmp,
    input  logic [3:0]     core_dout,
    output logic [3:0]     core_din,
    output logic [3:0]     instr,
    output logic [7:0]     pc,
    output logic           cs_err,
    input  logic           pl_we,
    input  logic [PAW-1:0] pl_addr,
    input  logic [3:0]     pl_data
);

    localparam int unsigned PDEPTH = 2 ** PAW;
    localparam int unsigned DDEPTH = 2 ** DAW;
    localparam logic [3:0]  PH_WRITE = 4'b0100;
    localparam logic [3:0]  PH_END   = 4'b1000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t         state;
    logic [3:0]     prog [PDEPTH];
    logic [3:0]     ram  [DDEPTH];
    logic [DAW-1:0] addr;
    logic [3:0]     prev_cs;
    logic [7:0]     next_pc;
    logic           cs_bad;

    always_comb begin
        next_pc = jmp ? db : pc + 8'd1;
    end

    // Illegal if multi-hot, or if it neither holds nor advances one phase from the last value.
    always_comb begin
        cs_bad = 1'b0;
        if (!$onehot0(cs)) begin
            cs_bad = 1'b1;
        end
        if ((prev_cs != 4'd0) && (cs != prev_cs) && (cs != {prev_cs[2:0], prev_cs[3]})) begin
            cs_bad = 1'b1;
        end
    end

    // Program store is loadable at any time and survives reset.
    always_ff @(posedge clk) begin
        if (pl_we) begin
            prog[pl_addr] <= pl_data;
        end
    end

    // Data RAM survives reset, but a write pending at reset is dropped.
    always_ff @(posedge clk) begin
        if (!rst && (cs == PH_WRITE) && write) begin
            ram[addr] <= core_dout;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pc       <= 8'd0;
            instr    <= 4'd0;
            core_din <= 4'd0;
            addr     <= '0;
            prev_cs  <= 4'd0;
            cs_err   <= 1'b0;
        end else begin
            prev_cs  <= cs;
            core_din <= ram[addr];
            if (cs_bad) begin
                cs_err <= 1'b1;
            end
            if ((cs == PH_END) && mar) begin
                addr <= db[DAW-1:0];
            end
            case (state)
                IDLE: begin
                    state <= PRIME;
                end
                PRIME: begin
                    instr <= prog[0];
                    state <= RUN;
                end
                RUN: begin
                    if (cs == PH_END) begin
                        pc    <= next_pc;
                        instr <= prog[next_pc[PAW-1:0]];
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_as5401_mem_ctrl.sv
// Directed bench for as5401_mem_ctrl: fetch sequencing, jump, wrap, RAM path,
// phase checker and mid-cycle reset, with hand-computed expectations.
module tb_as5401_mem_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] cs;
    logic [7:0] db;
    logic       mar;
    logic       write;
    logic       jmp;
    logic [3:0] core_dout;
    logic [3:0] core_din;
    logic [3:0] instr;
    logic [7:0] pc;
    logic       cs_err;
    logic       pl_we;
    logic [5:0] pl_addr;
    logic [3:0] pl_data;

    int total = 0;
    int bad   = 0;

    as5401_mem_ctrl #(.PAW(6), .DAW(4)) dut (
        .clk(clk), .rst(rst), .cs(cs), .db(db), .mar(mar), .write(write),
        .jmp(jmp), .core_dout(core_dout), .core_din(core_din), .instr(instr),
        .pc(pc), .cs_err(cs_err), .pl_we(pl_we), .pl_addr(pl_addr), .pl_data(pl_data)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic load(input logic [5:0] a, input logic [3:0] d);
        pl_we = 1'b1; pl_addr = a; pl_data = d;
        tick;
        pl_we = 1'b0;
    endtask

    // One full four-phase machine cycle; write strobe on phase 4, jmp/mar/db on phase 8.
    task automatic cycle(input logic j, input logic m, input logic w,
                         input logic [7:0] d, input logic [3:0] dout);
        cs = 4'b0001; tick;
        cs = 4'b0010; tick;
        cs = 4'b0100; write = w; core_dout = dout; tick;
        write = 1'b0;
        cs = 4'b1000; jmp = j; mar = m; db = d; tick;
        jmp = 1'b0; mar = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cs = 4'd0; db = 8'd0; mar = 1'b0; write = 1'b0; jmp = 1'b0;
        core_dout = 4'd0; pl_we = 1'b0; pl_addr = 6'd0; pl_data = 4'd0;
        tick;
        load(6'd0, 4'h2); load(6'd1, 4'h0); load(6'd2, 4'h5); load(6'd3, 4'h3);
        load(6'd5, 4'hF); load(6'd6, 4'hA); load(6'd7, 4'h6); load(6'd63, 4'h9);
        chk("rst_pc", pc, 8'h00);
        chk("rst_instr", 8'(instr), 8'h0);
        chk("rst_core_din", 8'(core_din), 8'h0);
        chk("rst_cs_err", 8'(cs_err), 8'h0);

        rst = 1'b0; cs = 4'd0;
        tick; tick; tick;
        chk("prime_instr", 8'(instr), 8'h2);
        chk("idle_cs_pc", pc, 8'h00);
        chk("idle_cs_err", 8'(cs_err), 8'h0);

        cycle(1'b0, 1'b0, 1'b0, 8'h00, 4'h0);
        chk("seq1_pc", pc, 8'h01);
        chk("seq1_instr", 8'(instr), 8'h0);
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 4'h0);
        chk("seq2_pc", pc, 8'h02);
        chk("seq2_instr", 8'(instr), 8'h5);
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 4'h0);
        chk("seq3_pc", pc, 8'h03);
        chk("seq3_instr", 8'(instr), 8'h3);

        cycle(1'b1, 1'b0, 1'b0, 8'h05, 4'h0);
        chk("jmp_pc", pc, 8'h05);
        chk("jmp_instr", 8'(instr), 8'hF);
        chk("normal_cs_err", 8'(cs_err), 8'h0);

        cycle(1'b0, 1'b1, 1'b0, 8'h07, 4'h0);
        chk("mar_pc", pc, 8'h06);
        chk("mar_instr", 8'(instr), 8'hA);
        cycle(1'b0, 1'b0, 1'b1, 8'h00, 4'h8);
        chk("wr_pc", pc, 8'h07);
        chk("wr_core_din", 8'(core_din), 8'h8);

        // Next cycle: check read data in phase 1, then jump to the top of the pc range.
        cs = 4'b0001; tick;
        chk("wr_core_din_ph1", 8'(core_din), 8'h8);
        cs = 4'b0010; tick;
        cs = 4'b0100; tick;
        cs = 4'b1000; jmp = 1'b1; db = 8'hFF; tick;
        jmp = 1'b0;
        chk("jmp_ff_pc", pc, 8'hFF);
        chk("jmp_ff_instr", 8'(instr), 8'h9);

        // Wrap to 0 while reloading prog[0] on the same edge: fetch sees old contents.
        cs = 4'b0001; tick;
        cs = 4'b0010; tick;
        cs = 4'b0100; tick;
        cs = 4'b1000; pl_we = 1'b1; pl_addr = 6'd0; pl_data = 4'hD; tick;
        pl_we = 1'b0;
        chk("wrap_pc", pc, 8'h00);
        chk("wrap_instr_prewrite", 8'(instr), 8'h2);
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 4'h0);
        chk("reload_instr", 8'(instr), 8'hD);

        // Reset in phase 4 with write asserted: write must be dropped.
        cs = 4'b0001; tick;
        cs = 4'b0010; tick;
        cs = 4'b0100; write = 1'b1; core_dout = 4'h3; rst = 1'b1; tick;
        chk("midrst_pc", pc, 8'h00);
        chk("midrst_instr", 8'(instr), 8'h0);
        chk("midrst_core_din", 8'(core_din), 8'h0);
        chk("midrst_cs_err", 8'(cs_err), 8'h0);
        rst = 1'b0; write = 1'b0; cs = 4'd0;
        tick; tick; tick;
        chk("midrst_prime_instr", 8'(instr), 8'hD);
        cycle(1'b0, 1'b1, 1'b0, 8'h07, 4'h0);
        chk("midrst_seq_pc", pc, 8'h01);
        chk("midrst_seq_instr", 8'(instr), 8'h0);
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 4'h0);
        chk("ram_preserved", 8'(core_din), 8'h8);
        chk("prog_preserved", 8'(instr), 8'h5);

        // Phase skip 1 -> 4.
        cs = 4'b0001; tick;
        cs = 4'b0100; tick;
        cs = 4'b1000; tick;
        chk("skip_cs_err", 8'(cs_err), 8'h1);
        cs = 4'b0001; tick;
        chk("skip_cs_err_sticky", 8'(cs_err), 8'h1);
        rst = 1'b1; tick;
        chk("skip_rst_clear", 8'(cs_err), 8'h0);
        rst = 1'b0; cs = 4'd0; tick;
        chk("post_rst_cs_err", 8'(cs_err), 8'h0);

        // Multi-hot phase value.
        cs = 4'b0011; tick; tick;
        chk("multihot_cs_err", 8'(cs_err), 8'h1);
        rst = 1'b1; tick;
        chk("multihot_rst_clear", 8'(cs_err), 8'h0);
        rst = 1'b0; cs = 4'd0; tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
